// File: rtl/mcp4725_i2c_responder.sv
// -----------------------------------------------------------------------------
// mcp4725_i2c_responder
//   I2C write-only target that behaves like the MCP4725 DAC in fast-write mode.
//   It decodes the device address, accepts byte pairs
//   {0 0 PD1 PD0 D11..D8} {D7..D0}, ACKs accepted bytes, and presents each
//   committed pair to fabric logic.
//
// Ports
//   clk        system clock (must run at least 8x sclk)
//   rst        asynchronous, active-low reset
//   sclk       bus clock from the master (asynchronous to clk)
//   sdata_in   bus data read back from the pad
//   sdata_out  bus data to the pad (only ever 0 while driving)
//   io_dir     1 = pad released, 0 = pad drives sdata_out
//   dac_value  last committed 12-bit DAC code
//   pd_mode    last committed PD1:PD0
//   data_valid one-clk pulse when dac_value/pd_mode update
//   cmd_err    one-clk pulse when a first data byte has C2:C1 != 00
//   busy       high from a valid START until STOP
// -----------------------------------------------------------------------------
module mcp4725_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'b1100110,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        sdata_in,
  output logic        sdata_out,
  output logic        io_dir,
  output logic [11:0] dac_value,
  output logic [1:0]  pd_mode,
  output logic        data_valid,
  output logic        cmd_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA1, ACK1, DATA2, ACK2, IGNORE
  } state_t;

  // Synchronizers reset to 1 so an idle (pulled-up) bus produces no edges.
  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_d_reg;
  logic                   sda_d_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], sclk};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sdata_in};
      scl_d_reg    <= scl_sync_reg[SYNC_STAGES-1];
      sda_d_reg    <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  logic scl, sda;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl      = scl_sync_reg[SYNC_STAGES-1];
  assign sda      = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d_reg;
  assign scl_fall = ~scl & scl_d_reg;
  // SCL must be high in both samples, so a simultaneous SCL/SDA change is
  // treated as ordinary data rather than a bus condition.
  assign start_cond = scl & scl_d_reg & sda_d_reg & ~sda;
  assign stop_cond  = scl & scl_d_reg & ~sda_d_reg & sda;

  state_t      state_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic        byte_rdy_reg;   // eight bits captured, waiting for the next SCL fall
  logic [1:0]  hold_pd_reg;
  logic [3:0]  hold_hi_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      byte_rdy_reg <= 1'b0;
      hold_pd_reg  <= 2'd0;
      hold_hi_reg  <= 4'd0;
      sdata_out    <= 1'b1;
      io_dir       <= 1'b1;
      dac_value    <= 12'd0;
      pd_mode      <= 2'd0;
      data_valid   <= 1'b0;
      cmd_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      cmd_err    <= 1'b0;

      if (start_cond) begin
        // Valid in every state, including a repeated START mid-frame.
        state_reg    <= ADDR;
        busy         <= 1'b1;
        io_dir       <= 1'b1;
        sdata_out    <= 1'b1;
        bit_cnt_reg  <= 3'd0;
        byte_rdy_reg <= 1'b0;
      end else if (stop_cond) begin
        state_reg    <= IDLE;
        busy         <= 1'b0;
        io_dir       <= 1'b1;
        sdata_out    <= 1'b1;
        bit_cnt_reg  <= 3'd0;
        byte_rdy_reg <= 1'b0;
      end else begin
        case (state_reg)
          ADDR, DATA1, DATA2: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) byte_rdy_reg <= 1'b1;
            end else if (scl_fall && byte_rdy_reg) begin
              byte_rdy_reg <= 1'b0;
              if (state_reg == ADDR) begin
                if (shift_reg[7:1] == DEV_ADDR && !shift_reg[0]) begin
                  io_dir    <= 1'b0;
                  sdata_out <= 1'b0;
                  state_reg <= ADDR_ACK;
                end else begin
                  state_reg <= IGNORE;
                end
              end else if (state_reg == DATA1) begin
                if (shift_reg[7:6] == 2'b00) begin
                  hold_pd_reg <= shift_reg[5:4];
                  hold_hi_reg <= shift_reg[3:0];
                  io_dir      <= 1'b0;
                  sdata_out   <= 1'b0;
                  state_reg   <= ACK1;
                end else begin
                  cmd_err   <= 1'b1;
                  state_reg <= IGNORE;
                end
              end else begin
                // Second byte of a pair: commit as the ACK drive begins.
                dac_value  <= {hold_hi_reg, shift_reg};
                pd_mode    <= hold_pd_reg;
                data_valid <= 1'b1;
                io_dir     <= 1'b0;
                sdata_out  <= 1'b0;
                state_reg  <= ACK2;
              end
            end
          end
          ADDR_ACK, ACK1, ACK2: begin
            if (scl_fall) begin
              io_dir      <= 1'b1;
              sdata_out   <= 1'b1;
              bit_cnt_reg <= 3'd0;
              state_reg   <= (state_reg == ACK1) ? DATA2 : DATA1;
            end
          end
          IDLE, IGNORE: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mcp4725_i2c_responder.md
Name: mcp4725_i2c_responder

Overview:
- I2C target (responder) that emulates the MCP4725 DAC write interface on the two-wire bus driven by our DAC master.
- Decodes the 7-bit address and fast-mode write frames (address byte, then one or more byte pairs).
- ACKs each accepted byte and presents the resulting 12-bit DAC code and power-down bits to fabric logic.
- Used as an on-FPGA DAC stand-in and as the bus-level checker for the master's transfers.

Parameters:
- DEV_ADDR, 7'b1100110, 7-bit target address; matches write byte 8'b11001100.
- SYNC_STAGES, 2, flip-flop depth of the sclk/sdata_in synchronizers (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- sclk  input  1  bus clock from the master, asynchronous to clk.
- sdata_in  input  1  bus data read back from the pad buffer.
- sdata_out  output  1  bus data to the pad buffer; only 0 is ever driven.
- io_dir  output  1  pad direction: 1 = input (released), 0 = drive sdata_out.
- dac_value  output  12  last committed DAC code.
- pd_mode  output  2  last committed PD1:PD0.
- data_valid  output  1  one-clk pulse when dac_value/pd_mode update.
- cmd_err  output  1  one-clk pulse when a first data byte has C2:C1 != 00.
- busy  output  1  high from a valid START until STOP.

Behaviour:
- Reset (rst low, async): sdata_out=1, io_dir=1, dac_value=0, pd_mode=0, data_valid=0, cmd_err=0, busy=0, state=IDLE, bit count=0. The bus is released immediately, even mid-ACK.
- Synchronize sclk and sdata_in through SYNC_STAGES FFs. Keep one extra delayed copy of each for edge detection. All decoding uses the synchronized signals only.
- START: sda falls while scl is high in both the current and previous sample. STOP: sda rises under the same condition. A cycle where scl and sda change together is data, not START/STOP.
- Data bits are sampled on scl rising edges, MSB first. A 3-bit counter counts to 8.
- ACK sequence:
  - On the scl falling edge after bit 8 of an accepted byte: io_dir=0, sdata_out=0.
  - On the next scl falling edge: io_dir=1, sdata_out=1, counter cleared.
- NACK: io_dir stays 1 throughout the 9th clock.
- States and transitions:
  - IDLE: wait for START, then busy=1 and go to ADDR.
  - ADDR: after 8 bits, if [7:1]==DEV_ADDR and R/W=0, go to ADDR_ACK. Otherwise go to IGNORE.
  - ADDR_ACK: drive ACK, then go to DATA1.
  - DATA1: after 8 bits, if [7:6]==00, latch [5:4] and [3:0] into holding registers and go to ACK1. Otherwise pulse cmd_err and go to IGNORE (NACK).
  - ACK1: drive ACK, then go to DATA2.
  - DATA2: after 8 bits, go to ACK2.
  - ACK2: in the clk cycle ACK drive begins, dac_value={held[3:0], byte2} and pd_mode=held[5:4], with data_valid pulsed for that cycle. After the ACK, go to DATA1 (repeated fast writes).
  - IGNORE: bus released; wait for STOP or START.
- START in any state (repeated start): release the bus, clear the counter, go to ADDR.
- STOP in any state: release the bus, go to IDLE, busy=0.
- A partial byte or unpaired DATA1 is discarded; no data_valid.
- dac_value and pd_mode hold until the next committed pair and are never cleared except by reset.
- data_valid and cmd_err are never high for more than one clk.
- Minimum ratio: clk ≥ 8× the sclk frequency. The master's 121-clk half-period satisfies this with wide margin.

Test Plan:
- Fast write START, 0xCC, 0x0A, 0xBC, STOP → io_dir=0 during three 9th clocks; dac_value=0xABC, pd_mode=00, one data_valid pulse, busy low after STOP.
- Address 0xCE (mismatch) then 0x0A, 0xBC, STOP → io_dir never 0, dac_value unchanged, no data_valid, state IDLE after STOP.
- Address 0xCD (read bit set) → NACK on address; first data byte 0x40 after a valid address → NACK plus one cmd_err pulse, dac_value unchanged.
- Continuous frame 0xCC, 0x01, 0x23, 0x2F, 0xFF, STOP → two data_valid pulses: 0x123/pd 00, then 0xFFF/pd 10; five ACKs.
- 0xCC, 0x05, STOP; then repeated START mid-DATA2 after 4 bits → no update, dac_value retains prior 0xABC; new frame after the START decodes normally.
- rst asserted while io_dir=0 during an ACK → io_dir=1 and sdata_out=1 with no clk edge; after release, IDLE, next frame 0xCC, 0x0F, 0xFF → dac_value=0xFFF.
